// File: rtl/sram_ctrl.sv
// sram_ctrl: multi-cycle bridge from the MEM stage to a 16-bit asynchronous SRAM.
// Each 32-bit access is split into a low and a high half-word SRAM cycle. The
// pipeline is stalled until the access completes, then it advances exactly once.
module sram_ctrl #(
  parameter int unsigned SRAM_AW  = 18,
  parameter int unsigned WAIT_CYC = 1
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_mem_rden,
  input  logic               i_mem_wren,
  input  logic [31:0]        i_addr,
  input  logic [31:0]        i_wdata,
  input  logic [3:0]         i_bmask,
  output logic [31:0]        o_rdata,
  output logic               o_rvalid,
  output logic               o_sram_stall,
  output logic [SRAM_AW-1:0] o_sram_addr,
  output logic [15:0]        o_sram_wdata,
  input  logic [15:0]        i_sram_rdata,
  output logic               o_sram_oe,
  output logic               o_sram_ce_n,
  output logic               o_sram_oe_n,
  output logic               o_sram_we_n,
  output logic               o_sram_lb_n,
  output logic               o_sram_ub_n
);

  localparam int unsigned WW = (WAIT_CYC > 0) ? $clog2(WAIT_CYC + 1) : 1;
  localparam logic [WW-1:0] WAIT_LOAD = WW'(WAIT_CYC);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] RD_LO = 3'd1;
  localparam logic [2:0] RD_HI = 3'd2;
  localparam logic [2:0] WR_LO = 3'd3;
  localparam logic [2:0] WR_HI = 3'd4;
  localparam logic [2:0] DONE  = 3'd5;

  logic [2:0]         state_q, state_d;
  logic [WW-1:0]      wcnt_q, wcnt_d;
  logic [SRAM_AW-2:0] word_q, word_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [3:0]         bmask_q, bmask_d;
  logic [15:0]        rlo_q, rlo_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               rvalid_q, rvalid_d;
  logic               req;
  logic               hi_sel;

  // Address bits outside the word index are deliberately ignored.
  logic unused_addr;
  assign unused_addr = ^{i_addr[31:SRAM_AW+1], i_addr[1:0]};

  assign req = i_mem_rden | i_mem_wren;

  // Next-state logic: access sequencing, wait counting and read-data capture.
  always_comb begin
    state_d  = state_q;
    wcnt_d   = wcnt_q;
    word_d   = word_q;
    wdata_d  = wdata_q;
    bmask_d  = bmask_q;
    rlo_d    = rlo_q;
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          word_d  = i_addr[SRAM_AW:2];
          wdata_d = i_wdata;
          bmask_d = i_bmask;
          wcnt_d  = WAIT_LOAD;
          // Store wins when both requests are present.
          if (!i_mem_wren)             state_d = RD_LO;
          else if (i_bmask[1:0] != '0) state_d = WR_LO;
          else if (i_bmask[3:2] != '0) state_d = WR_HI;
          else                         state_d = DONE;
        end
      end
      RD_LO: begin
        if (wcnt_q == '0) begin
          rlo_d   = i_sram_rdata;
          wcnt_d  = WAIT_LOAD;
          state_d = RD_HI;
        end else begin
          wcnt_d = wcnt_q - 1'b1;
        end
      end
      RD_HI: begin
        if (wcnt_q == '0) begin
          // o_rdata only changes on entry to DONE so it stays stable between loads.
          rdata_d  = {i_sram_rdata, rlo_q};
          rvalid_d = 1'b1;
          wcnt_d   = WAIT_LOAD;
          state_d  = DONE;
        end else begin
          wcnt_d = wcnt_q - 1'b1;
        end
      end
      WR_LO: begin
        if (wcnt_q == '0) begin
          wcnt_d  = WAIT_LOAD;
          state_d = (bmask_q[3:2] != '0) ? WR_HI : DONE;
        end else begin
          wcnt_d = wcnt_q - 1'b1;
        end
      end
      WR_HI: begin
        if (wcnt_q == '0) begin
          wcnt_d  = WAIT_LOAD;
          state_d = DONE;
        end else begin
          wcnt_d = wcnt_q - 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset; reset aborts any access in flight.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q  <= IDLE;
      wcnt_q   <= '0;
      word_q   <= '0;
      wdata_q  <= '0;
      bmask_q  <= '0;
      rlo_q    <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      wcnt_q   <= wcnt_d;
      word_q   <= word_d;
      wdata_q  <= wdata_d;
      bmask_q  <= bmask_d;
      rlo_q    <= rlo_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  // SRAM strobes, bus direction and stall decoded from the current state.
  always_comb begin
    o_sram_ce_n = 1'b1;
    o_sram_oe_n = 1'b1;
    o_sram_we_n = 1'b1;
    o_sram_lb_n = 1'b1;
    o_sram_ub_n = 1'b1;
    o_sram_oe   = 1'b0;
    hi_sel      = 1'b0;
    case (state_q)
      RD_LO, RD_HI: begin
        o_sram_ce_n = 1'b0;
        o_sram_oe_n = 1'b0;
        o_sram_lb_n = 1'b0;
        o_sram_ub_n = 1'b0;
        hi_sel      = (state_q == RD_HI);
      end
      WR_LO: begin
        o_sram_ce_n = 1'b0;
        o_sram_we_n = 1'b0;
        o_sram_oe   = 1'b1;
        o_sram_lb_n = ~bmask_q[0];
        o_sram_ub_n = ~bmask_q[1];
      end
      WR_HI: begin
        o_sram_ce_n = 1'b0;
        o_sram_we_n = 1'b0;
        o_sram_oe   = 1'b1;
        o_sram_lb_n = ~bmask_q[2];
        o_sram_ub_n = ~bmask_q[3];
        hi_sel      = 1'b1;
      end
      default: ;
    endcase
  end

  assign o_sram_addr  = {word_q, hi_sel};
  assign o_sram_wdata = hi_sel ? wdata_q[31:16] : wdata_q[15:0];
  assign o_sram_stall = ((state_q == IDLE) & req) | ((state_q != IDLE) & (state_q != DONE));
  assign o_rdata      = rdata_q;
  assign o_rvalid     = rvalid_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl: behavioural async SRAM, directed accesses, and a
// scoreboard that checks every o_rvalid pulse against queued expected loads.
module tb_sram_ctrl;

  localparam int unsigned AW = 18;

  logic          clk = 1'b0;
  logic          reset;
  logic          rden, wren;
  logic [31:0]   addr, wdata;
  logic [3:0]    bmask;
  logic [31:0]   rdata;
  logic          rvalid, stall;
  logic [AW-1:0] sram_addr;
  logic [15:0]   sram_wdata, sram_rdata;
  logic          sram_oe, ce_n, oe_n, we_n, lb_n, ub_n;

  sram_ctrl #(.SRAM_AW(AW), .WAIT_CYC(1)) dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_mem_rden   (rden),
    .i_mem_wren   (wren),
    .i_addr       (addr),
    .i_wdata      (wdata),
    .i_bmask      (bmask),
    .o_rdata      (rdata),
    .o_rvalid     (rvalid),
    .o_sram_stall (stall),
    .o_sram_addr  (sram_addr),
    .o_sram_wdata (sram_wdata),
    .i_sram_rdata (sram_rdata),
    .o_sram_oe    (sram_oe),
    .o_sram_ce_n  (ce_n),
    .o_sram_oe_n  (oe_n),
    .o_sram_we_n  (we_n),
    .o_sram_lb_n  (lb_n),
    .o_sram_ub_n  (ub_n)
  );

  always #5 clk = ~clk;

  // Async SRAM model: 256 half-words, combinational read, byte-lane writes.
  logic [15:0] mem [0:255];
  logic        pl_en = 1'b0;
  logic [7:0]  pl_addr;
  logic [15:0] pl_data;
  assign sram_rdata = mem[sram_addr[7:0]];

  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (!ce_n && !we_n) begin
      if (!lb_n) mem[sram_addr[7:0]][7:0]  <= sram_wdata[7:0];
      if (!ub_n) mem[sram_addr[7:0]][15:8] <= sram_wdata[15:8];
    end
  end

  typedef struct {
    logic [AW-1:0] a;
    logic [15:0]   wd;
    logic          we_n, oe_n, lb_n, ub_n, oe;
  } ent_t;

  ent_t        log_q[$];
  logic [31:0] sb[$];
  int          rv_cyc[$];
  int          cyc = 0;
  int          tests = 0;
  int          fails = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every rvalid pulse must match the oldest expected load.
  always @(negedge clk) begin
    if (rvalid) begin
      rv_cyc.push_back(cyc);
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_rvalid: got rdata 0x%0h expected no pulse", rdata);
      end else begin
        check("sb_rdata", rdata, sb.pop_front());
      end
    end
  end

  task automatic preload(input logic [7:0] a, input logic [15:0] d);
    @(posedge clk); #1;
    pl_addr = a; pl_data = d; pl_en = 1'b1;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  // Issues one access, logs every SRAM-active cycle, returns stall length.
  task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] bm,
                        input logic is_load, input logic [31:0] exp_data,
                        output int stalls);
    log_q.delete();
    stalls = 0;
    @(posedge clk); #1;
    rden = rd; wren = wr; addr = a; wdata = wd; bmask = bm;
    if (is_load) sb.push_back(exp_data);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!ce_n) log_q.push_back('{sram_addr, sram_wdata, we_n, oe_n, lb_n, ub_n, sram_oe});
      if (stall) stalls++;
      else break;
    end
    check("rvalid_in_done", {31'd0, rvalid}, {31'd0, is_load});
    rden = 1'b0; wren = 1'b0;
  endtask

  int          n;
  logic [11:0] pat;

  initial begin
    reset = 1'b1; rden = 1'b0; wren = 1'b0;
    addr = '0; wdata = '0; bmask = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_strobes", {27'd0, ce_n, oe_n, we_n, lb_n, ub_n}, 32'h1f);
    check("rst_rdata", rdata, 32'd0);
    check("rst_rvalid", {31'd0, rvalid}, 32'd0);
    check("rst_addr", {14'd0, sram_addr}, 32'd0);
    check("rst_wdata_oe", {15'd0, sram_wdata, sram_oe}, 32'd0);

    preload(8'd8, 16'hBEEF);
    preload(8'd9, 16'hDEAD);
    preload(8'd2, 16'h2222);
    preload(8'd3, 16'h1111);

    // 1: word load at 0x10
    access(1'b1, 1'b0, 32'h10, 32'd0, 4'h0, 1'b1, 32'hDEADBEEF, n);
    check("t1_stall", n, 5);
    check("t1_log_len", log_q.size(), 4);
    if (log_q.size() == 4) begin
      check("t1_addr_seq", {log_q[0].a[7:0], log_q[1].a[7:0], log_q[2].a[7:0], log_q[3].a[7:0]},
            32'h08080909);
      check("t1_rd_strobes", {28'd0, log_q[0].we_n, log_q[0].oe_n, log_q[3].lb_n, log_q[3].oe},
            32'h8);
    end

    // 2: full-word store at 0x20
    access(1'b0, 1'b1, 32'h20, 32'h12345678, 4'hF, 1'b0, 32'd0, n);
    check("t2_stall", n, 5);
    check("t2_log_len", log_q.size(), 4);
    if (log_q.size() == 4) begin
      check("t2_lo", {log_q[0].a[7:0], log_q[0].wd, 3'd0, log_q[0].we_n, log_q[0].lb_n,
                      log_q[0].ub_n, log_q[0].oe_n, log_q[0].oe}, {8'h10, 16'h5678, 8'h03});
      check("t2_hi", {log_q[2].a[7:0], log_q[2].wd, 8'd0}, {8'h11, 16'h1234, 8'h00});
    end
    @(negedge clk);
    check("t2_mem", {mem[8'h11], mem[8'h10]}, 32'h12345678);
    check("t2_rdata_hold", rdata, 32'hDEADBEEF);

    // 3: byte store, lane 2 only
    access(1'b0, 1'b1, 32'h4, 32'h00AB0000, 4'b0100, 1'b0, 32'd0, n);
    check("t3_stall", n, 3);
    check("t3_log_len", log_q.size(), 2);
    if (log_q.size() == 2)
      check("t3_hi", {log_q[0].a[7:0], 6'd0, log_q[0].lb_n, log_q[0].ub_n}, {8'h03, 8'h01});
    @(negedge clk);
    check("t3_mem", {mem[3], mem[2]}, 32'h11AB2222);

    // 4: rden and wren together -> store; then empty byte mask
    access(1'b1, 1'b1, 32'h30, 32'hCAFEF00D, 4'hF, 1'b0, 32'd0, n);
    check("t4_stall", n, 5);
    @(negedge clk);
    check("t4_mem", {mem[8'h19], mem[8'h18]}, 32'hCAFEF00D);
    access(1'b0, 1'b1, 32'h30, 32'h0, 4'h0, 1'b0, 32'd0, n);
    check("t4_bm0_stall", n, 1);
    check("t4_bm0_log", log_q.size(), 0);

    // 5: reset in the second cycle of RD_HI
    @(posedge clk); #1;
    rden = 1'b1; addr = 32'h10;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("t5_pre_stall_addr", {13'd0, stall, sram_addr}, {13'd1, 18'd9});
    reset = 1'b1; rden = 1'b0;
    @(negedge clk);
    check("t5_stall", {31'd0, stall}, 32'd0);
    check("t5_strobes", {27'd0, ce_n, oe_n, we_n, lb_n, ub_n}, 32'h1f);
    check("t5_rvalid", {31'd0, rvalid}, 32'd0);
    check("t5_rdata", rdata, 32'd0);
    @(posedge clk); #1 reset = 1'b0;
    repeat (6) @(negedge clk);

    // 6: back-to-back loads with request held across DONE
    rv_cyc.delete();
    @(posedge clk); #1;
    rden = 1'b1; addr = 32'h10;
    sb.push_back(32'hDEADBEEF);
    sb.push_back(32'hDEADBEEF);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      pat[i] = stall;
    end
    rden = 1'b0;
    repeat (3) @(negedge clk);
    check("t6_stall_pattern", {20'd0, pat}, {20'd0, 12'b011111011111});
    check("t6_rv_count", rv_cyc.size(), 2);
    if (rv_cyc.size() == 2) check("t6_rv_gap", rv_cyc[1] - rv_cyc[0], 6);

    check("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
